// File: rtl/yx_soe_recorder.sv
// Sequence-of-events recorder for debounced YX inputs: timestamps every state
// change into a small FIFO drained by the CPU, with sticky overflow and IRQ.
module yx_soe_recorder #(
    parameter int YX_WIDTH = 4,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int MS_DIV   = 1000
) (
    input  logic                            clk_in,
    input  logic                            rst_n,
    input  logic [YX_WIDTH-1:0]             yx_state,
    input  logic                            rd_pop,
    input  logic                            clr_ts,
    input  logic                            ovf_clr,
    output logic [2*YX_WIDTH+TS_WIDTH-1:0]  rd_data,
    output logic                            rd_valid,
    output logic [$clog2(DEPTH):0]          fifo_cnt,
    output logic                            ovf,
    output logic [TS_WIDTH-1:0]             ts_now,
    output logic                            soe_irq
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PS_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int REC_W = 2*YX_WIDTH + TS_WIDTH;

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(MS_DIV - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    logic [PS_W-1:0]     ps;
    logic                tick;
    logic                arm;
    logic [YX_WIDTH-1:0] prev;
    logic                evt;
    logic                empty;
    logic                full;
    logic                pop_ok;
    logic                push_ok;
    logic                drop;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [REC_W-1:0]    mem [DEPTH];

    assign tick = (ps == PS_MAX);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ps     <= '0;
            ts_now <= '0;
        end else if (clr_ts) begin
            ps     <= '0;
            ts_now <= '0;
        end else if (tick) begin
            ps     <= '0;
            ts_now <= ts_now + TS_WIDTH'(1);
        end else begin
            ps     <= ps + PS_W'(1);
        end
    end

    // The first edge after reset only captures the baseline; changes are
    // reported from the second edge on.
    assign evt = arm && (yx_state != prev);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            arm  <= 1'b0;
            prev <= '0;
        end else if (!arm) begin
            arm  <= 1'b1;
            prev <= yx_state;
        end else if (evt) begin
            prev <= yx_state;
        end
    end

    assign empty   = (fifo_cnt == '0);
    assign full    = (fifo_cnt == CNT_FULL);
    assign pop_ok  = rd_pop && !empty;
    assign push_ok = evt && (!full || pop_ok);
    assign drop    = evt && !push_ok;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= {yx_state ^ prev, yx_state, ts_now};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (pop_ok && !push_ok) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign soe_irq  = rd_valid || ovf;

endmodule

// File: tb/tb_yx_soe_recorder.sv
// Directed table-driven bench for yx_soe_recorder; a second small instance
// covers timestamp wrap and clr_ts/tick precedence in few cycles.
module tb_yx_soe_recorder;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  yx_state;
    logic        rd_pop;
    logic        clr_ts;
    logic        ovf_clr;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [3:0]  fifo_cnt;
    logic        ovf;
    logic [15:0] ts_now;
    logic        soe_irq;

    logic        rst2_n;
    logic [3:0]  yx2;
    logic        pop2;
    logic        clr2;
    logic        oclr2;
    logic [15:0] rd_data2;
    logic        rd_valid2;
    logic [2:0]  fifo_cnt2;
    logic        ovf2;
    logic [7:0]  ts2;
    logic        irq2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    yx_soe_recorder #(.YX_WIDTH(4), .DEPTH(8), .TS_WIDTH(16), .MS_DIV(10)) u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .yx_state(yx_state), .rd_pop(rd_pop),
        .clr_ts(clr_ts), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_cnt(fifo_cnt), .ovf(ovf), .ts_now(ts_now), .soe_irq(soe_irq)
    );

    yx_soe_recorder #(.YX_WIDTH(4), .DEPTH(4), .TS_WIDTH(8), .MS_DIV(4)) u_ts (
        .clk_in(clk_in), .rst_n(rst2_n), .yx_state(yx2), .rd_pop(pop2),
        .clr_ts(clr2), .ovf_clr(oclr2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .fifo_cnt(fifo_cnt2), .ovf(ovf2), .ts_now(ts2), .soe_irq(irq2)
    );

    typedef struct {
        logic [3:0]  yx;
        logic        pop;
        logic        oclr;
        logic        vld;
        logic [3:0]  cnt;
        logic [23:0] data;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] yx, input logic pop, input logic oclr,
                               input logic vld, input logic [3:0] cnt,
                               input logic [23:0] data, input logic o);
        vec_t r;
        r.yx = yx; r.pop = pop; r.oclr = oclr; r.vld = vld;
        r.cnt = cnt; r.data = data; r.ovf = o;
        return r;
    endfunction

    function automatic logic [23:0] rec(input logic [3:0] m, input logic [3:0] s,
                                        input logic [15:0] t);
        return {m, s, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; yx_state = 4'h0; rd_pop = 1'b0; clr_ts = 1'b0; ovf_clr = 1'b0;
        rst2_n = 1'b0; yx2 = 4'h0; pop2 = 1'b0; clr2 = 1'b0; oclr2 = 1'b0;

        // Edge numbers below count from reset release; with MS_DIV=10 the
        // record ts is floor((edge-1)/10).
        tbl.push_back(v(4'h5, 0, 0, 1, 1, rec(4'h5, 4'h5, 3), 0));  // e31
        tbl.push_back(v(4'h5, 1, 0, 0, 0, 24'h0, 0));
        tbl.push_back(v(4'h6, 0, 0, 1, 1, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'h7, 0, 0, 1, 2, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'h8, 0, 0, 1, 3, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'h9, 0, 0, 1, 4, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'hA, 0, 0, 1, 5, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'hB, 0, 0, 1, 6, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'hC, 0, 0, 1, 7, rec(4'h3, 4'h6, 3), 0));
        tbl.push_back(v(4'hD, 0, 0, 1, 8, rec(4'h3, 4'h6, 3), 0));  // e40 full
        tbl.push_back(v(4'hE, 0, 1, 1, 8, rec(4'h3, 4'h6, 3), 1));  // drop beats ovf_clr
        tbl.push_back(v(4'hE, 1, 0, 1, 7, rec(4'h1, 4'h7, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 6, rec(4'hF, 4'h8, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 5, rec(4'h1, 4'h9, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 4, rec(4'h3, 4'hA, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 3, rec(4'h1, 4'hB, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 2, rec(4'h7, 4'hC, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 1, 1, rec(4'h1, 4'hD, 3), 1));
        tbl.push_back(v(4'hE, 1, 0, 0, 0, 24'h0, 1));
        tbl.push_back(v(4'hE, 0, 1, 0, 0, 24'h0, 0));               // e50 ovf_clr
        tbl.push_back(v(4'h0, 0, 0, 1, 1, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h1, 0, 0, 1, 2, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h2, 0, 0, 1, 3, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h3, 0, 0, 1, 4, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h4, 0, 0, 1, 5, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h5, 0, 0, 1, 6, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h6, 0, 0, 1, 7, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h7, 0, 0, 1, 8, rec(4'hE, 4'h0, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 8, rec(4'h1, 4'h1, 5), 0));  // full push+pop
        tbl.push_back(v(4'h8, 1, 0, 1, 7, rec(4'h3, 4'h2, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 6, rec(4'h1, 4'h3, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 5, rec(4'h7, 4'h4, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 4, rec(4'h1, 4'h5, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 3, rec(4'h3, 4'h6, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 2, rec(4'h1, 4'h7, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 1, 1, rec(4'hF, 4'h8, 5), 0));
        tbl.push_back(v(4'h8, 1, 0, 0, 0, 24'h0, 0));
        tbl.push_back(v(4'h8, 1, 0, 0, 0, 24'h0, 0));               // e68 empty pop
        tbl.push_back(v(4'h9, 0, 0, 1, 1, rec(4'h1, 4'h9, 6), 0));
        tbl.push_back(v(4'h9, 1, 0, 0, 0, 24'h0, 0));               // e70

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_ts_now", 32'(ts_now), 32'h0);
        chk("rst_soe_irq", 32'(soe_irq), 32'h0);

        rst_n = 1'b1;
        repeat (30) step();
        chk("ts_after_3ms", 32'(ts_now), 32'd3);
        chk("no_rec_idle", 32'(fifo_cnt), 32'd0);

        foreach (tbl[i]) begin
            yx_state = tbl[i].yx;
            rd_pop   = tbl[i].pop;
            ovf_clr  = tbl[i].oclr;
            step();
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(tbl[i].data));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("v%0d_irq", i), 32'(soe_irq), 32'(tbl[i].vld | tbl[i].ovf));
        end
        rd_pop = 1'b0;
        ovf_clr = 1'b0;
        chk("ts_after_tbl", 32'(ts_now), 32'd7);

        // Mid-operation reset loses the FIFO; yx=F held across release must not record.
        yx_state = 4'hF;
        step();
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        chk("mid_rst_ts", 32'(ts_now), 32'd0);
        chk("mid_rst_irq", 32'(soe_irq), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arm_no_rec", 32'(fifo_cnt), 32'd0);
        yx_state = 4'hE;
        step();
        chk("arm_rec_valid", 32'(rd_valid), 32'd1);
        chk("arm_rec_data", 32'(rd_data), 32'(rec(4'h1, 4'hE, 0)));
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
        chk("arm_pop_cnt", 32'(fifo_cnt), 32'd0);
        chk("arm_pop_irq", 32'(soe_irq), 32'd0);

        // Timestamp wrap and clr_ts over a coincident tick (MS_DIV=4, 8-bit ts).
        rst2_n = 1'b1;
        repeat (1023) step();
        chk("ts_pre_wrap", 32'(ts2), 32'd255);
        step();
        chk("ts_wrap", 32'(ts2), 32'd0);
        repeat (7) step();
        chk("ts_before_clr", 32'(ts2), 32'd1);
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        chk("ts_clr_over_tick", 32'(ts2), 32'd0);
        repeat (3) step();
        chk("ts_clr_hold", 32'(ts2), 32'd0);
        step();
        chk("ts_clr_next_inc", 32'(ts2), 32'd1);
        chk("ts_dut_cnt", 32'(fifo_cnt2), 32'd0);
        chk("ts_dut_idle", 32'({rd_data2, rd_valid2, ovf2, irq2}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
